rr_prio_arb: RTL and testbench
==============================

RR_PRIO_ARB -- requirements
Module: rr_prio_arb

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning number of requesters (legal range 2..32).
REQ-002 The block SHALL have parameter MODE, default 0, meaning 0 = fixed priority and 1 = round-robin.
REQ-003 The block SHALL have parameter MAX_HOLD, default 0, meaning maximum grant cycles before forced release (0 = unlimited, otherwise 1..255).
REQ-004 The block SHALL derive IW = max(1, clog2(N)) for the index width.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 Port `clk`: input, 1 bit; the single clock, all state updates on rising edge.
REQ-007 Port `reset`: input, 1 bit; asynchronous, active-high reset.
REQ-008 Port `req`: input, N bits; request vector, bit i = requester i.
REQ-009 Port `done`: input, 1 bit; the granted requester releases the grant.
REQ-010 Port `gnt`: output, N bits; registered one-hot grant, all-zero when idle.
REQ-011 Port `gnt_id`: output, IW bits; registered binary index of the granted requester.
REQ-012 Port `valid`: output, 1 bit; registered; high when a grant is held.

Function
REQ-013 FSM SHALL have two states: IDLE and GRANT.
REQ-014 IDLE with req != 0 at a rising edge SHALL move to GRANT at that edge, loading gnt, gnt_id and valid=1 (one-cycle latency from sampled req).
REQ-015 IDLE with req == 0 SHALL stay in IDLE with gnt=0, gnt_id=0, valid=0.
REQ-016 MODE=0 SHALL grant the highest set index of req (bit N-1 highest priority).
REQ-017 MODE=1 SHALL keep a pointer P (IW bits); search starts at P and proceeds downward (P, P-1, ..., 0, N-1, ...), and the first set bit wins.
REQ-018 MODE=1 SHALL set P = (granted index - 1) mod N on each release; P is unchanged otherwise.
REQ-019 In GRANT, gnt/gnt_id SHALL be held stable regardless of req changes on other bits.
REQ-020 Release SHALL occur at an edge in GRANT where any of these hold: done=1; req[gnt_id]=0 (abort); or MAX_HOLD>0 and the hold counter = MAX_HOLD-1.
REQ-021 Release SHALL move to IDLE and clear gnt, gnt_id and valid; exactly one idle cycle always separates consecutive grants.
REQ-022 Hold counter SHALL be 8 bits: cleared on entry to GRANT and incremented each GRANT cycle without release; with MAX_HOLD=M, valid stays high for at most M consecutive cycles.
REQ-023 Simultaneous release causes (done + abort + timeout) SHALL produce a single release and a single pointer update.
REQ-024 done in IDLE SHALL be ignored.
REQ-025 gnt SHALL always be zero or one-hot; valid=1 iff gnt != 0; gnt_id SHALL equal the index of the set gnt bit.

Reset
REQ-026 reset=1 SHALL immediately (asynchronously) force state IDLE, gnt=0, gnt_id=0, valid=0, hold counter=0 and P=N-1, including mid-grant.
REQ-027 After reset deasserts, the first grant SHALL be identical in both modes.
REQ-028 No release side effects (pointer update) SHALL occur due to reset.

Verification (N=4)
REQ-029 MODE=0, req=0101 in IDLE -> after next edge gnt=0100, gnt_id=2, valid=1.
REQ-030 MODE=0, granted 2, req changes to 1101 with done=0 -> gnt stays 0100; done=1 -> IDLE cycle, then gnt=1000, gnt_id=3.
REQ-031 MODE=1, req=1111 constant, done pulsed each grant cycle -> gnt_id sequence 3,2,1,0,3 with valid pattern 1,0,1,0,...
REQ-032 MAX_HOLD=3, req=0010 held, done=0 -> valid high exactly 3 cycles, low 1 cycle, then re-grant gnt_id=1.
REQ-033 Grant held on id 2, reset pulsed between edges -> gnt/valid drop to 0 without a clock edge; after release of reset, MODE=1 with req=1111 grants id 3.
REQ-034 req=0000 for 10 cycles -> valid=0, gnt=0 throughout; abort check: granted id 1, req[1] drops -> IDLE at next edge.

Source files
------------

// File: rtl/rr_prio_arb.sv
// Request arbiter with fixed-priority or round-robin selection, optional
// forced release after MAX_HOLD cycles, and a registered one-hot grant.
module rr_prio_arb #(
  parameter int N        = 4,
  parameter int MODE     = 0,
  parameter int MAX_HOLD = 0,
  localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  gnt_nxt;
  logic [IW-1:0] id_nxt, ptr, ptr_nxt, pick_id, sidx;
  logic          valid_nxt, found, hold_to, release_now;
  logic [7:0]    hold, hold_nxt;

  // Winner selection: highest set index, or first set bit walking down from ptr.
  always_comb begin
    pick_id = '0;
    found   = 1'b0;
    sidx    = '0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++)
        if (req[i]) pick_id = IW'(i);
    end else begin
      for (int k = 0; k < N; k++) begin
        sidx = (ptr >= IW'(k)) ? ptr - IW'(k) : ptr + IW'(N - k);
        if (!found && req[sidx]) begin
          pick_id = sidx;
          found   = 1'b1;
        end
      end
    end
  end

  assign hold_to     = (MAX_HOLD != 0) && (hold == 8'(MAX_HOLD - 1));
  assign release_now = (state == GRANT) && (done || !req[gnt_id] || hold_to);

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    valid_nxt = valid;
    hold_nxt  = hold;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << pick_id;
          id_nxt    = pick_id;
          valid_nxt = 1'b1;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          id_nxt    = '0;
          valid_nxt = 1'b0;
          hold_nxt  = '0;
          // Next search starts just below the requester that was served.
          if (MODE == 1)
            ptr_nxt = (gnt_id == '0) ? IW'(N - 1) : gnt_id - 1'b1;
        end else begin
          hold_nxt = hold + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      valid  <= 1'b0;
      hold   <= '0;
      ptr    <= IW'(N - 1);
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      gnt_id <= id_nxt;
      valid  <= valid_nxt;
      hold   <= hold_nxt;
      ptr    <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_prio_arb.sv
// Bench for rr_prio_arb: three configurations driven by shared stimulus,
// directed vectors/sequences plus random traffic against a reference model.
module tb_rr_prio_arb;
  localparam int N = 4;

  logic         clk = 1'b0, reset = 1'b0, done = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt [3];
  logic [1:0]   gid [3];
  logic         vld [3];

  rr_prio_arb #(.N(N), .MODE(0), .MAX_HOLD(0)) u0 (.clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(gnt[0]), .gnt_id(gid[0]), .valid(vld[0]));
  rr_prio_arb #(.N(N), .MODE(1), .MAX_HOLD(0)) u1 (.clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(gnt[1]), .gnt_id(gid[1]), .valid(vld[1]));
  rr_prio_arb #(.N(N), .MODE(0), .MAX_HOLD(3)) u2 (.clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(gnt[2]), .gnt_id(gid[2]), .valid(vld[2]));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Reference model: busy flag, served index, cycles held so far, search start.
  int cfg_mode [3] = '{0, 1, 0};
  int cfg_mh   [3] = '{0, 0, 3};
  int m_busy [3], m_id [3], m_cyc [3], m_ptr [3];

  function automatic void m_reset();
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 0; m_id[k] = 0; m_cyc[k] = 0; m_ptr[k] = N - 1;
    end
  endfunction

  function automatic void m_step(input logic [N-1:0] r, input logic d);
    for (int k = 0; k < 3; k++) begin
      if (m_busy[k] != 0) begin
        if (d || !r[m_id[k]] || (cfg_mh[k] > 0 && m_cyc[k] == cfg_mh[k])) begin
          m_busy[k] = 0;
          m_ptr[k]  = (m_id[k] + N - 1) % N;
        end else m_cyc[k]++;
      end else if (r != 0) begin
        int p = -1;
        if (cfg_mode[k] == 0) begin
          for (int i = 0; i < N; i++) if (r[i]) p = i;
        end else begin
          for (int j = 0; j < N; j++) begin
            int idx = (m_ptr[k] - j + N) % N;
            if (p < 0 && r[idx]) p = idx;
          end
        end
        m_busy[k] = 1; m_id[k] = p; m_cyc[k] = 1;
      end
    end
  endfunction

  function automatic int m_word(input int k);
    if (m_busy[k] == 0) return 0;
    return (1 << m_id[k]) | (m_id[k] << 4) | (1 << 6);
  endfunction

  function automatic int dut_word(input int k);
    return int'({vld[k], gid[k], gnt[k]});
  endfunction

  function automatic int word(input logic v, input int id, input logic [N-1:0] g);
    return int'({v, id[1:0], g});
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got {valid,id,gnt}=%02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic d);
    req = r; done = d;
    m_step(r, d);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req = '0; done = 1'b0;
    reset = 1'b1; #2;
    m_reset();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] r;
    logic         d;
    logic [N-1:0] g;
    int           id;
    logic         v;
  } vec_t;
  vec_t tbl [9];

  int exp_rr [5] = '{3, 2, 1, 0, 3};

  initial begin
    tbl[0] = '{4'b0101, 1'b0, 4'b0100, 2, 1'b1};
    tbl[1] = '{4'b1101, 1'b0, 4'b0100, 2, 1'b1};
    tbl[2] = '{4'b1101, 1'b1, 4'b0000, 0, 1'b0};
    tbl[3] = '{4'b1101, 1'b0, 4'b1000, 3, 1'b1};
    tbl[4] = '{4'b1101, 1'b1, 4'b0000, 0, 1'b0};
    tbl[5] = '{4'b0010, 1'b0, 4'b0010, 1, 1'b1};
    tbl[6] = '{4'b0000, 1'b0, 4'b0000, 0, 1'b0};
    tbl[7] = '{4'b0000, 1'b1, 4'b0000, 0, 1'b0};
    tbl[8] = '{4'b0000, 1'b0, 4'b0000, 0, 1'b0};

    reset = 1'b1; #3;
    for (int k = 0; k < 3; k++) chk($sformatf("reset_u%0d", k), dut_word(k), 0);
    m_reset();
    reset = 1'b0;

    // Fixed-priority vectors: hold stability, done release, abort, idle done.
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].r, tbl[i].d);
      chk($sformatf("vec%0d", i), dut_word(0), word(tbl[i].v, tbl[i].id, tbl[i].g));
    end

    // Round-robin rotation with done pulsed every cycle.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(4'hF, 1'b1);
      if (i % 2 == 0) chk($sformatf("rr%0d", i), dut_word(1), word(1'b1, exp_rr[i/2], 4'(1 << exp_rr[i/2])));
      else            chk($sformatf("rr%0d", i), dut_word(1), 0);
    end

    // Timeout: three cycles granted, one idle, re-grant.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0010, 1'b0);
      chk($sformatf("hold%0d", i), dut_word(2), (i == 3) ? 0 : word(1'b1, 1, 4'b0010));
    end

    // Asynchronous reset mid-grant, pointer must return to N-1.
    do_reset();
    cyc(4'b0100, 1'b0);
    chk("pre_areset", dut_word(1), word(1'b1, 2, 4'b0100));
    reset = 1'b1; #1;
    for (int k = 0; k < 3; k++) chk($sformatf("areset_u%0d", k), dut_word(k), 0);
    #1 reset = 1'b0;
    m_reset();
    cyc(4'hF, 1'b0);
    chk("post_areset_rr", dut_word(1), word(1'b1, 3, 4'b1000));
    chk("post_areset_fp", dut_word(0), word(1'b1, 3, 4'b1000));

    // Quiet requests (done toggling is ignored in idle), then abort.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(4'b0000, 1'(i % 2));
      chk($sformatf("quiet%0d", i), dut_word(0), 0);
    end
    cyc(4'b0010, 1'b0);
    chk("abort_gnt", dut_word(1), word(1'b1, 1, 4'b0010));
    cyc(4'b0000, 1'b0);
    chk("abort_rel", dut_word(1), 0);

    // Random traffic against the model; requests change occasionally so grants persist.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] r;
      r = req;
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        r = '0;
      end
      cyc(r, ($urandom_range(0, 4) == 0));
      for (int k = 0; k < 3; k++) chk($sformatf("rand%0d_u%0d", i, k), dut_word(k), m_word(k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
